// File: rtl/vtage_pkg.sv
// Shared types and counter arithmetic for the VTAGE tagged table.
// Field widths here must match the width parameters of vtage_table.
package vtage_pkg;

  parameter int unsigned VTAGE_VALUE_W = 8;
  parameter int unsigned VTAGE_TAG_W   = 8;
  parameter int unsigned VTAGE_CONF_W  = 3;
  parameter int unsigned VTAGE_U_W     = 2;

  typedef struct packed {
    logic                     valid;
    logic [VTAGE_CONF_W:0]    conf;
    logic [VTAGE_TAG_W-1:0]   tag;
    logic [VTAGE_U_W-1:0]     useful;
    logic [VTAGE_VALUE_W-1:0] value;
  } vtage_entry_t;

  typedef enum logic {
    AGE_IDLE  = 1'b0,
    AGE_SWEEP = 1'b1
  } vtage_age_state_e;

  // Confidence saturates once its MSB is set, i.e. at 2^VTAGE_CONF_W.
  function automatic logic [VTAGE_CONF_W:0] conf_inc(input logic [VTAGE_CONF_W:0] c);
    return c[VTAGE_CONF_W] ? c : c + 1'b1;
  endfunction

  function automatic logic [VTAGE_U_W-1:0] useful_inc(input logic [VTAGE_U_W-1:0] u);
    return (&u) ? u : u + 1'b1;
  endfunction

  function automatic logic [VTAGE_U_W-1:0] useful_dec(input logic [VTAGE_U_W-1:0] u);
    return (u == '0) ? u : u - 1'b1;
  endfunction

endpackage

// File: rtl/vtage_table_age_ctrl.sv
// Aging controller: counts failed allocations and, at threshold, sweeps every
// entry once (one per cycle) while holding off updates.
module vtage_age_ctrl
  import vtage_pkg::*;
#(
  parameter int unsigned P_DEPTH      = 256,
  parameter int unsigned P_AGE_THRESH = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       fail_i,
  output logic                       sweep_en_o,
  output logic [$clog2(P_DEPTH)-1:0] sweep_ptr_o,
  output logic                       ready_o
);

  localparam int unsigned LP_IDX_WIDTH = $clog2(P_DEPTH);
  localparam int unsigned LP_CNT_WIDTH = $clog2(P_AGE_THRESH + 1);

  vtage_age_state_e          state_q, state_d;
  logic [LP_CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [LP_IDX_WIDTH-1:0]   ptr_q, ptr_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= AGE_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      AGE_IDLE: begin
        if (fail_i) begin
          // The failure that reaches the threshold starts the sweep directly.
          if (cnt_q == LP_CNT_WIDTH'(P_AGE_THRESH - 1)) begin
            state_d = AGE_SWEEP;
            cnt_d   = '0;
            ptr_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      AGE_SWEEP: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LP_IDX_WIDTH'(P_DEPTH - 1)) begin
          state_d = AGE_IDLE;
          ptr_d   = '0;
        end
      end
      default: state_d = AGE_IDLE;
    endcase
  end

  assign sweep_en_o  = (state_q == AGE_SWEEP);
  assign sweep_ptr_o = ptr_q;
  assign ready_o     = (state_q == AGE_IDLE);

endmodule

// File: rtl/vtage_table.sv
// VTAGE tagged component: registered lookup port, handshaked update port with
// tag compare, allocation and confidence/useful maintenance, periodic aging.
module vtage_table
  import vtage_pkg::*;
#(
  parameter int unsigned P_DEPTH       = 256,
  parameter int unsigned P_VALUE_WIDTH = VTAGE_VALUE_W,
  parameter int unsigned P_TAG_WIDTH   = VTAGE_TAG_W,
  parameter int unsigned P_CONF_WIDTH  = VTAGE_CONF_W,
  parameter int unsigned P_U_WIDTH     = VTAGE_U_W,
  parameter int unsigned P_AGE_THRESH  = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       pred_req_i,
  input  logic [$clog2(P_DEPTH)-1:0] pred_idx_i,
  input  logic [P_TAG_WIDTH-1:0]     pred_tag_i,
  output logic                       pred_valid_o,
  output logic                       pred_hit_o,
  output logic [P_VALUE_WIDTH-1:0]   pred_value_o,
  output logic [P_CONF_WIDTH:0]      pred_conf_o,
  output logic                       pred_confident_o,
  output logic [P_U_WIDTH-1:0]       pred_useful_o,
  input  logic                       upd_valid_i,
  output logic                       upd_ready_o,
  input  logic [$clog2(P_DEPTH)-1:0] upd_idx_i,
  input  logic [P_TAG_WIDTH-1:0]     upd_tag_i,
  input  logic [P_VALUE_WIDTH-1:0]   upd_value_i,
  input  logic                       upd_correct_i,
  input  logic                       upd_alloc_i,
  output logic                       upd_done_o,
  output logic                       upd_hit_o,
  output logic                       upd_alloc_ok_o,
  output logic                       upd_alloc_fail_o,
  output logic                       aging_o
);

  localparam int unsigned LP_IDX_WIDTH = $clog2(P_DEPTH);

  // Control fields are reset; tag/value live in separate unreset storage.
  logic                     vld_q    [P_DEPTH];
  logic [P_CONF_WIDTH:0]    conf_q   [P_DEPTH];
  logic [P_U_WIDTH-1:0]     useful_q [P_DEPTH];
  logic [P_TAG_WIDTH-1:0]   tag_q    [P_DEPTH];
  logic [P_VALUE_WIDTH-1:0] value_q  [P_DEPTH];

  logic                    sweep_en;
  logic [LP_IDX_WIDTH-1:0] sweep_ptr;
  logic                    ready;
  logic                    upd_fire, upd_hit, upd_u_zero;
  logic                    alloc_ok, alloc_fail;
  vtage_entry_t            pred_ent;

  logic                     pred_valid_q, pred_hit_q, pred_confident_q;
  logic [P_VALUE_WIDTH-1:0] pred_value_q;
  logic [P_CONF_WIDTH:0]    pred_conf_q;
  logic [P_U_WIDTH-1:0]     pred_useful_q;
  logic                     done_q, hit_q, alloc_ok_q, alloc_fail_q;

  vtage_age_ctrl #(
    .P_DEPTH      (P_DEPTH),
    .P_AGE_THRESH (P_AGE_THRESH)
  ) u_age_ctrl (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .fail_i      (alloc_fail),
    .sweep_en_o  (sweep_en),
    .sweep_ptr_o (sweep_ptr),
    .ready_o     (ready)
  );

  assign upd_fire   = upd_valid_i & ready;
  assign upd_hit    = vld_q[upd_idx_i] && (tag_q[upd_idx_i] == upd_tag_i);
  assign upd_u_zero = (useful_q[upd_idx_i] == '0);
  assign alloc_ok   = upd_fire & ~upd_hit & upd_alloc_i & upd_u_zero;
  assign alloc_fail = upd_fire & ~upd_hit & upd_alloc_i & ~upd_u_zero;

  always_comb begin
    pred_ent.valid  = vld_q[pred_idx_i];
    pred_ent.conf   = conf_q[pred_idx_i];
    pred_ent.tag    = tag_q[pred_idx_i];
    pred_ent.useful = useful_q[pred_idx_i];
    pred_ent.value  = value_q[pred_idx_i];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(P_DEPTH); i++) begin
        vld_q[i]    <= 1'b0;
        conf_q[i]   <= '0;
        useful_q[i] <= '0;
      end
    end else begin
      // Sweep and update never overlap: updates are not accepted while sweeping.
      if (sweep_en) begin
        useful_q[sweep_ptr] <= useful_q[sweep_ptr] >> 1;
      end
      if (upd_fire) begin
        if (upd_hit) begin
          if (upd_correct_i) begin
            conf_q[upd_idx_i]   <= conf_inc(conf_q[upd_idx_i]);
            useful_q[upd_idx_i] <= useful_inc(useful_q[upd_idx_i]);
          end else begin
            conf_q[upd_idx_i]   <= '0;
            useful_q[upd_idx_i] <= useful_dec(useful_q[upd_idx_i]);
          end
        end else if (upd_alloc_i) begin
          if (upd_u_zero) begin
            vld_q[upd_idx_i]    <= 1'b1;
            conf_q[upd_idx_i]   <= '0;
            useful_q[upd_idx_i] <= '0;
          end else begin
            useful_q[upd_idx_i] <= useful_dec(useful_q[upd_idx_i]);
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (upd_fire && upd_hit && !upd_correct_i) begin
      value_q[upd_idx_i] <= upd_value_i;
    end else if (alloc_ok) begin
      tag_q[upd_idx_i]   <= upd_tag_i;
      value_q[upd_idx_i] <= upd_value_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pred_valid_q     <= 1'b0;
      pred_hit_q       <= 1'b0;
      pred_value_q     <= '0;
      pred_conf_q      <= '0;
      pred_confident_q <= 1'b0;
      pred_useful_q    <= '0;
      done_q           <= 1'b0;
      hit_q            <= 1'b0;
      alloc_ok_q       <= 1'b0;
      alloc_fail_q     <= 1'b0;
    end else begin
      pred_valid_q <= pred_req_i;
      if (pred_req_i) begin
        pred_hit_q       <= pred_ent.valid && (pred_ent.tag == pred_tag_i);
        pred_value_q     <= pred_ent.value;
        pred_conf_q      <= pred_ent.conf;
        pred_confident_q <= pred_ent.conf[P_CONF_WIDTH];
        pred_useful_q    <= pred_ent.useful;
      end
      done_q       <= upd_fire;
      hit_q        <= upd_fire & upd_hit;
      alloc_ok_q   <= alloc_ok;
      alloc_fail_q <= alloc_fail;
    end
  end

  assign pred_valid_o     = pred_valid_q;
  assign pred_hit_o       = pred_hit_q;
  assign pred_value_o     = pred_value_q;
  assign pred_conf_o      = pred_conf_q;
  assign pred_confident_o = pred_confident_q;
  assign pred_useful_o    = pred_useful_q;
  assign upd_ready_o      = ready;
  assign upd_done_o       = done_q;
  assign upd_hit_o        = hit_q;
  assign upd_alloc_ok_o   = alloc_ok_q;
  assign upd_alloc_fail_o = alloc_fail_q;
  assign aging_o          = sweep_en;

endmodule

// File: tb/tb_vtage_table.sv
// Directed bench for vtage_table in a small configuration (8 entries, aging after 2 failures).
module tb_vtage_table;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pred_req;
  logic [2:0] pred_idx;
  logic [7:0] pred_tag;
  logic       pred_valid, pred_hit, pred_confident;
  logic [7:0] pred_value;
  logic [3:0] pred_conf;
  logic [1:0] pred_useful;
  logic       upd_valid, upd_ready;
  logic [2:0] upd_idx;
  logic [7:0] upd_tag, upd_value;
  logic       upd_correct, upd_alloc;
  logic       upd_done, upd_hit, upd_alloc_ok, upd_alloc_fail, aging;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vtage_table #(
    .P_DEPTH      (8),
    .P_AGE_THRESH (2)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .pred_req_i       (pred_req),
    .pred_idx_i       (pred_idx),
    .pred_tag_i       (pred_tag),
    .pred_valid_o     (pred_valid),
    .pred_hit_o       (pred_hit),
    .pred_value_o     (pred_value),
    .pred_conf_o      (pred_conf),
    .pred_confident_o (pred_confident),
    .pred_useful_o    (pred_useful),
    .upd_valid_i      (upd_valid),
    .upd_ready_o      (upd_ready),
    .upd_idx_i        (upd_idx),
    .upd_tag_i        (upd_tag),
    .upd_value_i      (upd_value),
    .upd_correct_i    (upd_correct),
    .upd_alloc_i      (upd_alloc),
    .upd_done_o       (upd_done),
    .upd_hit_o        (upd_hit),
    .upd_alloc_ok_o   (upd_alloc_ok),
    .upd_alloc_fail_o (upd_alloc_fail),
    .aging_o          (aging)
  );

  // Drivers: each returns 1ns after the accepting edge, where responses are visible.
  task automatic do_lookup(input logic [2:0] idx, input logic [7:0] tag);
    pred_req = 1'b1; pred_idx = idx; pred_tag = tag;
    @(posedge clk); #1;
    pred_req = 1'b0;
  endtask

  task automatic do_update(input logic [2:0] idx, input logic [7:0] tag, input logic [7:0] val,
                           input logic corr, input logic alloc);
    upd_valid = 1'b1; upd_idx = idx; upd_tag = tag; upd_value = val;
    upd_correct = corr; upd_alloc = alloc;
    @(posedge clk); #1;
    upd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pred_req = 1'b0; pred_idx = '0; pred_tag = '0;
    upd_valid = 1'b0; upd_idx = '0; upd_tag = '0; upd_value = '0;
    upd_correct = 1'b0; upd_alloc = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (pred_valid !== 1'b0) begin n_fail++; $display("FAIL rst_pred_valid got %0h want 0", pred_valid); end
    n_checks++; if (upd_done !== 1'b0) begin n_fail++; $display("FAIL rst_upd_done got %0h want 0", upd_done); end
    n_checks++; if (aging !== 1'b0) begin n_fail++; $display("FAIL rst_aging got %0h want 0", aging); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (upd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_upd_ready got %0h want 1", upd_ready); end
  endtask

  task automatic test_empty_lookup();
    do_lookup(3'd5, 8'h3A);
    n_checks++; if (pred_valid !== 1'b1) begin n_fail++; $display("FAIL empty_valid got %0h want 1", pred_valid); end
    n_checks++; if (pred_hit !== 1'b0) begin n_fail++; $display("FAIL empty_hit got %0h want 0", pred_hit); end
    n_checks++; if (pred_conf !== 4'd0) begin n_fail++; $display("FAIL empty_conf got %0h want 0", pred_conf); end
    n_checks++; if (pred_useful !== 2'd0) begin n_fail++; $display("FAIL empty_useful got %0h want 0", pred_useful); end
    n_checks++; if (upd_ready !== 1'b1) begin n_fail++; $display("FAIL empty_ready got %0h want 1", upd_ready); end
    @(posedge clk); #1;
    n_checks++; if (pred_valid !== 1'b0) begin n_fail++; $display("FAIL valid_drop got %0h want 0", pred_valid); end
  endtask

  task automatic test_alloc();
    do_update(3'd5, 8'h3A, 8'h77, 1'b0, 1'b1);
    n_checks++; if (upd_done !== 1'b1) begin n_fail++; $display("FAIL alloc_done got %0h want 1", upd_done); end
    n_checks++; if (upd_alloc_ok !== 1'b1) begin n_fail++; $display("FAIL alloc_ok got %0h want 1", upd_alloc_ok); end
    n_checks++; if (upd_hit !== 1'b0) begin n_fail++; $display("FAIL alloc_hit got %0h want 0", upd_hit); end
    n_checks++; if (upd_alloc_fail !== 1'b0) begin n_fail++; $display("FAIL alloc_fail got %0h want 0", upd_alloc_fail); end
    @(posedge clk); #1;
    n_checks++; if (upd_done !== 1'b0) begin n_fail++; $display("FAIL done_pulse got %0h want 0", upd_done); end
    do_lookup(3'd5, 8'h3A);
    n_checks++; if (pred_hit !== 1'b1) begin n_fail++; $display("FAIL alloc_lk_hit got %0h want 1", pred_hit); end
    n_checks++; if (pred_value !== 8'h77) begin n_fail++; $display("FAIL alloc_lk_value got %0h want 77", pred_value); end
    n_checks++; if (pred_conf !== 4'd0) begin n_fail++; $display("FAIL alloc_lk_conf got %0h want 0", pred_conf); end
    do_lookup(3'd5, 8'h3B);
    n_checks++; if (pred_hit !== 1'b0) begin n_fail++; $display("FAIL tag_mismatch_hit got %0h want 0", pred_hit); end
  endtask

  task automatic test_confidence();
    for (int k = 1; k <= 9; k++) begin
      do_update(3'd5, 8'h3A, 8'h77, 1'b1, 1'b0);
      n_checks++; if (upd_hit !== 1'b1) begin n_fail++; $display("FAIL conf_upd_hit[%0d] got %0h want 1", k, upd_hit); end
      do_lookup(3'd5, 8'h3A);
      n_checks++; if (pred_conf !== 4'((k > 8) ? 8 : k)) begin n_fail++; $display("FAIL conf_value[%0d] got %0d want %0d", k, pred_conf, (k > 8) ? 8 : k); end
      n_checks++; if (pred_confident !== (k >= 8)) begin n_fail++; $display("FAIL conf_confident[%0d] got %0h want %0h", k, pred_confident, k >= 8); end
      n_checks++; if (pred_useful !== 2'((k > 3) ? 3 : k)) begin n_fail++; $display("FAIL conf_useful[%0d] got %0d want %0d", k, pred_useful, (k > 3) ? 3 : k); end
    end
  endtask

  task automatic test_incorrect();
    pred_req = 1'b1; pred_idx = 3'd5; pred_tag = 8'h3A;
    do_update(3'd5, 8'h3A, 8'h12, 1'b0, 1'b0);
    pred_req = 1'b0;
    n_checks++; if (pred_value !== 8'h77) begin n_fail++; $display("FAIL rw_old_value got %0h want 77", pred_value); end
    n_checks++; if (pred_conf !== 4'd8) begin n_fail++; $display("FAIL rw_old_conf got %0d want 8", pred_conf); end
    n_checks++; if (upd_hit !== 1'b1) begin n_fail++; $display("FAIL incorr_hit got %0h want 1", upd_hit); end
    do_lookup(3'd5, 8'h3A);
    n_checks++; if (pred_conf !== 4'd0) begin n_fail++; $display("FAIL incorr_conf got %0d want 0", pred_conf); end
    n_checks++; if (pred_value !== 8'h12) begin n_fail++; $display("FAIL incorr_value got %0h want 12", pred_value); end
    n_checks++; if (pred_useful !== 2'd2) begin n_fail++; $display("FAIL incorr_useful got %0d want 2", pred_useful); end
    do_update(3'd5, 8'h3A, 8'h00, 1'b0, 1'b0);
    do_update(3'd5, 8'h3A, 8'h12, 1'b1, 1'b0);
    do_update(3'd5, 8'h3A, 8'h12, 1'b1, 1'b0);
    do_update(3'd5, 8'h3A, 8'h12, 1'b0, 1'b0);
    do_lookup(3'd5, 8'h3A);
    n_checks++; if (pred_useful !== 2'd2) begin n_fail++; $display("FAIL useful_walk got %0d want 2", pred_useful); end
  endtask

  task automatic test_no_alloc_miss();
    do_update(3'd6, 8'h20, 8'h01, 1'b0, 1'b0);
    n_checks++; if ({upd_done, upd_hit, upd_alloc_ok, upd_alloc_fail} !== 4'b1000) begin n_fail++; $display("FAIL noalloc_flags got %b want 1000", {upd_done, upd_hit, upd_alloc_ok, upd_alloc_fail}); end
    do_lookup(3'd6, 8'h20);
    n_checks++; if (pred_hit !== 1'b0) begin n_fail++; $display("FAIL noalloc_hit got %0h want 0", pred_hit); end
  endtask

  task automatic test_aging();
    int n_age;
    do_update(3'd2, 8'h11, 8'h44, 1'b0, 1'b1);
    n_checks++; if (upd_alloc_ok !== 1'b1) begin n_fail++; $display("FAIL age_setup_alloc got %0h want 1", upd_alloc_ok); end
    repeat (3) do_update(3'd2, 8'h11, 8'h44, 1'b1, 1'b0);
    do_update(3'd5, 8'h55, 8'h99, 1'b0, 1'b1);
    n_checks++; if (upd_alloc_fail !== 1'b1) begin n_fail++; $display("FAIL blocked1_fail got %0h want 1", upd_alloc_fail); end
    n_checks++; if (aging !== 1'b0) begin n_fail++; $display("FAIL blocked1_aging got %0h want 0", aging); end
    do_update(3'd5, 8'h55, 8'h99, 1'b0, 1'b1);
    n_checks++; if (upd_alloc_fail !== 1'b1) begin n_fail++; $display("FAIL blocked2_fail got %0h want 1", upd_alloc_fail); end
    n_checks++; if (upd_done !== 1'b1) begin n_fail++; $display("FAIL blocked2_done got %0h want 1", upd_done); end
    n_checks++; if (aging !== 1'b1) begin n_fail++; $display("FAIL sweep_start got %0h want 1", aging); end
    n_age = (aging === 1'b1) ? 1 : 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (aging !== 1'b1) break;
      n_age++;
      n_checks++; if (upd_ready !== 1'b0) begin n_fail++; $display("FAIL sweep_ready[%0d] got %0h want 0", c, upd_ready); end
    end
    n_checks++; if (n_age !== 8) begin n_fail++; $display("FAIL sweep_len got %0d want 8", n_age); end
    n_checks++; if (upd_ready !== 1'b1) begin n_fail++; $display("FAIL sweep_ready_back got %0h want 1", upd_ready); end
    do_lookup(3'd2, 8'h11);
    n_checks++; if (pred_useful !== 2'd1) begin n_fail++; $display("FAIL aged_useful got %0d want 1", pred_useful); end
    n_checks++; if (pred_conf !== 4'd3) begin n_fail++; $display("FAIL aged_conf got %0d want 3", pred_conf); end
    do_lookup(3'd5, 8'h3A);
    n_checks++; if ({pred_hit, pred_value} !== {1'b1, 8'h12}) begin n_fail++; $display("FAIL blocked_kept got %0h/%0h want 1/12", pred_hit, pred_value); end
    n_checks++; if (pred_useful !== 2'd0) begin n_fail++; $display("FAIL blocked_useful got %0d want 0", pred_useful); end
  endtask

  task automatic test_reset_mid_sweep();
    repeat (2) do_update(3'd2, 8'h11, 8'h44, 1'b1, 1'b0);
    do_update(3'd2, 8'h99, 8'h01, 1'b0, 1'b1);
    do_update(3'd2, 8'h99, 8'h01, 1'b0, 1'b1);
    n_checks++; if (aging !== 1'b1) begin n_fail++; $display("FAIL sweep2_start got %0h want 1", aging); end
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (aging !== 1'b0) begin n_fail++; $display("FAIL midsweep_aging got %0h want 0", aging); end
    n_checks++; if (pred_valid !== 1'b0) begin n_fail++; $display("FAIL midsweep_pvalid got %0h want 0", pred_valid); end
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (upd_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready got %0h want 1", upd_ready); end
    n_checks++; if (aging !== 1'b0) begin n_fail++; $display("FAIL post_rst_aging got %0h want 0", aging); end
    do_lookup(3'd5, 8'h3A);
    n_checks++; if (pred_hit !== 1'b0) begin n_fail++; $display("FAIL post_rst_hit5 got %0h want 0", pred_hit); end
    n_checks++; if (pred_conf !== 4'd0) begin n_fail++; $display("FAIL post_rst_conf5 got %0d want 0", pred_conf); end
    do_lookup(3'd2, 8'h11);
    n_checks++; if (pred_hit !== 1'b0) begin n_fail++; $display("FAIL post_rst_hit2 got %0h want 0", pred_hit); end
    n_checks++; if (pred_useful !== 2'd0) begin n_fail++; $display("FAIL post_rst_useful2 got %0d want 0", pred_useful); end
  endtask

  initial begin
    test_reset();
    test_empty_lookup();
    test_alloc();
    test_confidence();
    test_incorrect();
    test_no_alloc_miss();
    test_aging();
    test_reset_mid_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
